// File: rtl/exc_pkg.sv
// Shared constants for the exception unit: default parameters, SPR map,
// controller states and internal cause numbering.
package exc_pkg;

  localparam int          DEF_NCAUSE      = 32;
  localparam int          DEF_NINT        = 8;
  localparam int          DEF_NNMI        = 1;
  localparam logic [31:0] DEF_REPEAT_MASK = 32'h0000_0018;
  localparam int          DEF_DW          = 32;

  localparam logic [2:0] SPR_SR    = 3'd0;
  localparam logic [2:0] SPR_ESR   = 3'd1;
  localparam logic [2:0] SPR_ECA   = 3'd2;
  localparam logic [2:0] SPR_EPC   = 3'd3;
  localparam logic [2:0] SPR_EDATA = 3'd4;
  localparam logic [2:0] SPR_MODE  = 3'd5;
  localparam logic [2:0] SPR_EMODE = 3'd6;
  localparam logic [2:0] SPR_PEND  = 3'd7;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  localparam int CAUSE_RESET = 0;
  localparam int CAUSE_ILL   = 1;
  localparam int CAUSE_MAL   = 2;
  localparam int CAUSE_PFF   = 3;
  localparam int CAUSE_PFLS  = 4;
  localparam int CAUSE_SYSC  = 5;
  localparam int CAUSE_OVF   = 6;

endpackage

// File: rtl/exc_prio_enc.sv
// Lowest-index-wins priority encoder; idx is 0 when nothing is set.
module exc_prio_enc #(
  parameter int N  = 32,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan from the top so the lowest set bit is the last one to assign idx.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/exception_unit.sv
// Exception/interrupt controller: cause assembly and masking, external line
// synchronisation, SPR file, ISR entry/return and double-fault halt.
//
//   state | meaning
//   RUN   | normal operation, causes may enter the handler
//   HALT  | double fault taken, core stopped until rst
import exc_pkg::*;

module exception_unit #(
  parameter int                NCAUSE      = DEF_NCAUSE,
  parameter int                NINT        = DEF_NINT,
  parameter int                NNMI        = DEF_NNMI,
  parameter logic [NCAUSE-1:0] REPEAT_MASK = NCAUSE'(DEF_REPEAT_MASK),
  parameter int                DW          = DEF_DW
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NINT-1:0]             ca_int,
  input  logic                        stage_valid,
  input  logic [NCAUSE-NINT-1:0]      ext_irq,
  input  logic [DW-1:0]               pc,
  input  logic [DW-1:0]               next_pc,
  input  logic [DW-1:0]               ea,
  input  logic                        rfe,
  input  logic [2:0]                  spr_sel,
  input  logic                        spr_we,
  input  logic [DW-1:0]               spr_wdata,
  output logic [DW-1:0]               spr_rdata,
  output logic [NCAUSE-1:0]           mca,
  output logic [$clog2(NCAUSE)-1:0]   il,
  output logic                        jisr,
  output logic                        mode,
  output logic                        abort
);

  localparam int NEXT = NCAUSE - NINT;

  state_e            state_q, state_d;
  logic [DW-1:0]     sr, esr, eca, epc, edata;
  logic              mode_q, emode_q, in_isr;
  logic [NEXT-1:0]   sync1, sync2, sync3, rise, pending, pend_clr;
  logic [NCAUSE-1:0] ca_eff, pend_view;
  logic              any_cause, dbl_fault, upd_ok;

  assign ca_eff    = {pending, ca_int & {NINT{stage_valid}}};
  assign pend_view = {pending, {NINT{1'b0}}};
  assign rise      = sync2 & ~sync3;
  assign mode      = mode_q;

  // Non-maskable causes pass unconditionally, the rest are gated by SR.
  always_comb begin
    mca = '0;
    for (int i = 0; i < NCAUSE; i++) begin
      mca[i] = ca_eff[i] & ((i < NNMI) || sr[i]);
    end
  end

  exc_prio_enc #(.N(NCAUSE)) u_prio (
    .vec (mca),
    .idx (il),
    .any (any_cause)
  );

  // Controller next state and entry/abort decisions.
  always_comb begin
    state_d   = state_q;
    dbl_fault = 1'b0;
    jisr      = 1'b0;
    abort     = 1'b0;
    upd_ok    = 1'b0;
    unique case (state_q)
      RUN: begin
        // A cause while already in a handler with everything masked
        // cannot be serviced: stop instead of clobbering the saved state.
        dbl_fault = any_cause && in_isr && (sr == '0);
        jisr      = any_cause && !dbl_fault;
        upd_ok    = !dbl_fault;
        if (dbl_fault) state_d = HALT;
      end
      HALT: begin
        abort = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  // Controller state register; only rst leaves HALT.
  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // External lines: two-flop synchroniser plus an edge-detect stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= ext_irq;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // Clear the pending bit that is being serviced this edge.
  always_comb begin
    pend_clr = '0;
    for (int i = 0; i < NEXT; i++) begin
      pend_clr[i] = jisr && (int'(il) == NINT + i);
    end
  end

  // Pending latch; a fresh edge on the serviced line keeps it set.
  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= (pending & ~pend_clr) | rise;
  end

  // SPR updates with precedence entry > rfe > software write.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr      <= '0;
      esr     <= '0;
      eca     <= '0;
      epc     <= '0;
      edata   <= '0;
      mode_q  <= 1'b0;
      emode_q <= 1'b0;
      in_isr  <= 1'b0;
    end else if (jisr) begin
      esr     <= sr;
      sr      <= '0;
      eca     <= DW'(mca);
      epc     <= REPEAT_MASK[il] ? pc : next_pc;
      edata   <= ea;
      emode_q <= mode_q;
      mode_q  <= 1'b0;
      in_isr  <= 1'b1;
    end else if (upd_ok) begin
      if (rfe) begin
        sr     <= esr;
        mode_q <= emode_q;
        in_isr <= 1'b0;
      end
      if (spr_we) begin
        case (spr_sel)
          SPR_SR:    if (!rfe) sr <= spr_wdata;
          SPR_ESR:   esr <= spr_wdata;
          SPR_ECA:   eca <= spr_wdata;
          SPR_EPC:   epc <= spr_wdata;
          SPR_EDATA: edata <= spr_wdata;
          SPR_MODE:  if (!rfe) mode_q <= spr_wdata[0];
          SPR_EMODE: emode_q <= spr_wdata[0];
          default:   ;
        endcase
      end
    end
  end

  // Combinational SPR read port.
  always_comb begin
    spr_rdata = '0;
    case (spr_sel)
      SPR_SR:    spr_rdata = sr;
      SPR_ESR:   spr_rdata = esr;
      SPR_ECA:   spr_rdata = eca;
      SPR_EPC:   spr_rdata = epc;
      SPR_EDATA: spr_rdata = edata;
      SPR_MODE:  spr_rdata = {{(DW-1){1'b0}}, mode_q};
      SPR_EMODE: spr_rdata = {{(DW-1){1'b0}}, emode_q};
      SPR_PEND:  spr_rdata = DW'(pend_view);
      default:   spr_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_exception_unit.sv
// Directed bench for exception_unit: a table of single-entry vectors plus
// hand-written multi-cycle sequences.
module tb_exception_unit;
  import exc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ca_int;
  logic        stage_valid;
  logic [23:0] ext_irq;
  logic [31:0] pc, next_pc, ea;
  logic        rfe;
  logic [2:0]  spr_sel;
  logic        spr_we;
  logic [31:0] spr_wdata;
  logic [31:0] spr_rdata;
  logic [31:0] mca;
  logic [4:0]  il;
  logic        jisr, mode, abort;

  int nvec = 0;
  int nerr = 0;

  exception_unit dut (
    .clk(clk), .rst(rst), .ca_int(ca_int), .stage_valid(stage_valid),
    .ext_irq(ext_irq), .pc(pc), .next_pc(next_pc), .ea(ea), .rfe(rfe),
    .spr_sel(spr_sel), .spr_we(spr_we), .spr_wdata(spr_wdata),
    .spr_rdata(spr_rdata), .mca(mca), .il(il), .jisr(jisr), .mode(mode),
    .abort(abort)
  );

  always #50 clk = ~clk;

  typedef struct {
    logic [31:0] sr_init;
    logic        sv;
    logic [7:0]  ca;
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] exp_mca;
    logic [4:0]  exp_il;
    logic        exp_jisr;
    logic [31:0] exp_epc;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    ca_int = '0; stage_valid = 1'b0; ext_irq = '0;
    pc = '0; next_pc = '0; ea = '0; rfe = 1'b0;
    spr_sel = '0; spr_we = 1'b0; spr_wdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic spr_write(input logic [2:0] sel, input logic [31:0] data);
    spr_sel = sel; spr_wdata = data; spr_we = 1'b1;
    tick();
    spr_we = 1'b0; spr_wdata = '0;
  endtask

  task automatic chk_spr(input string name, input logic [2:0] sel, input logic [31:0] exp);
    spr_sel = sel;
    #1;
    check(name, spr_rdata, exp);
  endtask

  initial begin
    //        sr_init       sv  ca     pc        npc       mca          il  jisr epc
    vecs[0] = '{32'hFFFF_FFFF, 1, 8'h42, 32'h100, 32'h104, 32'h0000_0042, 1, 1, 32'h104};
    vecs[1] = '{32'hFFFF_FFFF, 1, 8'h08, 32'h200, 32'h204, 32'h0000_0008, 3, 1, 32'h200};
    vecs[2] = '{32'hFFFF_FFFF, 1, 8'h10, 32'h300, 32'h304, 32'h0000_0010, 4, 1, 32'h300};
    vecs[3] = '{32'h0000_0000, 1, 8'h42, 32'h100, 32'h104, 32'h0000_0000, 0, 0, 32'h0};
    vecs[4] = '{32'h0000_0000, 1, 8'h01, 32'h400, 32'h404, 32'h0000_0001, 0, 1, 32'h404};
    vecs[5] = '{32'h0000_0040, 1, 8'h60, 32'h500, 32'h504, 32'h0000_0040, 6, 1, 32'h504};
    vecs[6] = '{32'hFFFF_FFFF, 0, 8'h80, 32'h100, 32'h104, 32'h0000_0000, 0, 0, 32'h0};
    vecs[7] = '{32'h0000_0018, 1, 8'h1C, 32'h600, 32'h604, 32'h0000_0018, 3, 1, 32'h600};

    // Reset state.
    do_reset();
    check("rst_jisr", {31'b0, jisr}, 32'h0);
    check("rst_abort", {31'b0, abort}, 32'h0);
    check("rst_mca", mca, 32'h0);
    check("rst_il", {27'b0, il}, 32'h0);
    for (int s = 0; s < 8; s++) chk_spr($sformatf("rst_spr%0d", s), 3'(s), 32'h0);

    // Table: one exception entry per vector from a fresh reset.
    for (int v = 0; v < 8; v++) begin
      do_reset();
      spr_write(SPR_SR, vecs[v].sr_init);
      stage_valid = vecs[v].sv; ca_int = vecs[v].ca;
      pc = vecs[v].pc; next_pc = vecs[v].npc; ea = vecs[v].pc + 32'h8;
      #1;
      check($sformatf("v%0d_mca", v), mca, vecs[v].exp_mca);
      check($sformatf("v%0d_il", v), {27'b0, il}, {27'b0, vecs[v].exp_il});
      check($sformatf("v%0d_jisr", v), {31'b0, jisr}, {31'b0, vecs[v].exp_jisr});
      tick();
      clear_inputs();
      chk_spr($sformatf("v%0d_eca", v), SPR_ECA, vecs[v].exp_jisr ? vecs[v].exp_mca : 32'h0);
      chk_spr($sformatf("v%0d_epc", v), SPR_EPC, vecs[v].exp_epc);
      chk_spr($sformatf("v%0d_edata", v), SPR_EDATA, vecs[v].exp_jisr ? vecs[v].pc + 32'h8 : 32'h0);
      chk_spr($sformatf("v%0d_sr", v), SPR_SR, vecs[v].exp_jisr ? 32'h0 : vecs[v].sr_init);
      chk_spr($sformatf("v%0d_esr", v), SPR_ESR, vecs[v].exp_jisr ? vecs[v].sr_init : 32'h0);
      check($sformatf("v%0d_mode", v), {31'b0, mode}, 32'h0);
    end

    // External line 0: two-cycle synchronisation latency, entry, clear.
    do_reset();
    spr_write(SPR_SR, 32'hFFFF_FFFF);
    ext_irq[0] = 1'b1;
    tick();
    ext_irq[0] = 1'b0;
    chk_spr("ext_pend_k", SPR_PEND, 32'h0);
    tick();
    chk_spr("ext_pend_k1", SPR_PEND, 32'h0);
    check("ext_jisr_k1", {31'b0, jisr}, 32'h0);
    tick();
    chk_spr("ext_pend_k2", SPR_PEND, 32'h100);
    check("ext_jisr_k2", {31'b0, jisr}, 32'h1);
    check("ext_il_k2", {27'b0, il}, 32'd8);
    tick();
    chk_spr("ext_eca", SPR_ECA, 32'h100);
    chk_spr("ext_pend_clr", SPR_PEND, 32'h0);
    chk_spr("ext_sr", SPR_SR, 32'h0);
    check("ext_jisr_after", {31'b0, jisr}, 32'h0);

    // New rising edge on the line being serviced keeps pending set.
    do_reset();
    ext_irq[0] = 1'b1;
    tick();
    ext_irq[0] = 1'b0;
    tick();
    ext_irq[0] = 1'b1;
    tick();
    ext_irq[0] = 1'b0;
    chk_spr("col_pend_pre", SPR_PEND, 32'h100);
    spr_write(SPR_SR, 32'hFFFF_FFFF);
    check("col_jisr", {31'b0, jisr}, 32'h1);
    check("col_il", {27'b0, il}, 32'd8);
    tick();
    chk_spr("col_eca", SPR_ECA, 32'h100);
    chk_spr("col_pend_kept", SPR_PEND, 32'h100);

    // Repeat-type entry then rfe restores SR and MODE.
    do_reset();
    spr_write(SPR_SR, 32'h0000_00F8);
    spr_write(SPR_MODE, 32'h1);
    check("rfe_mode_pre", {31'b0, mode}, 32'h1);
    stage_valid = 1'b1; ca_int = 8'h08; pc = 32'h200; next_pc = 32'h204;
    #1;
    check("rfe_entry_jisr", {31'b0, jisr}, 32'h1);
    tick();
    clear_inputs();
    chk_spr("rfe_epc", SPR_EPC, 32'h200);
    chk_spr("rfe_sr_in", SPR_SR, 32'h0);
    check("rfe_mode_in", {31'b0, mode}, 32'h0);
    chk_spr("rfe_emode", SPR_EMODE, 32'h1);
    chk_spr("rfe_esr", SPR_ESR, 32'hF8);
    rfe = 1'b1;
    tick();
    rfe = 1'b0;
    chk_spr("rfe_sr_out", SPR_SR, 32'hF8);
    check("rfe_mode_out", {31'b0, mode}, 32'h1);

    // Masked external line waits in PEND until SR enables it.
    do_reset();
    ext_irq[3] = 1'b1;
    tick(); tick(); tick();
    check("msk_jisr", {31'b0, jisr}, 32'h0);
    chk_spr("msk_pend", SPR_PEND, 32'h800);
    spr_write(SPR_SR, 32'h800);
    check("msk_jisr_en", {31'b0, jisr}, 32'h1);
    check("msk_il", {27'b0, il}, 32'd11);
    tick();
    chk_spr("msk_eca", SPR_ECA, 32'h800);
    chk_spr("msk_pend_clr", SPR_PEND, 32'h0);
    ext_irq[3] = 1'b0;

    // Double fault: halt, no SPR update, writes ignored, rst recovers.
    do_reset();
    spr_write(SPR_SR, 32'hFFFF_FFFF);
    stage_valid = 1'b1; ca_int = 8'h02;
    tick();
    ca_int = 8'h01;
    #1;
    check("dbl_jisr", {31'b0, jisr}, 32'h0);
    check("dbl_abort_pre", {31'b0, abort}, 32'h0);
    tick();
    clear_inputs();
    spr_write(SPR_SR, 32'h55);
    rfe = 1'b1; ext_irq[1] = 1'b1;
    tick();
    rfe = 1'b0; ext_irq[1] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      check($sformatf("dbl_abort_c%0d", c), {31'b0, abort}, 32'h1);
      check($sformatf("dbl_jisr_c%0d", c), {31'b0, jisr}, 32'h0);
      tick();
    end
    chk_spr("dbl_sr", SPR_SR, 32'h0);
    chk_spr("dbl_eca", SPR_ECA, 32'h2);
    chk_spr("dbl_pend", SPR_PEND, 32'h200);
    do_reset();
    check("dbl_abort_rst", {31'b0, abort}, 32'h0);
    for (int s = 0; s < 8; s++) chk_spr($sformatf("dbl_rst_spr%0d", s), 3'(s), 32'h0);

    // Same edge: entry beats rfe and SR write; then rfe beats SR write.
    do_reset();
    spr_write(SPR_SR, 32'hFF);
    spr_write(SPR_ESR, 32'hAA);
    stage_valid = 1'b1; ca_int = 8'h02; rfe = 1'b1;
    spr_sel = SPR_SR; spr_wdata = 32'h33; spr_we = 1'b1;
    #1;
    check("prec_jisr", {31'b0, jisr}, 32'h1);
    tick();
    clear_inputs();
    chk_spr("prec_sr", SPR_SR, 32'h0);
    chk_spr("prec_esr", SPR_ESR, 32'hFF);
    chk_spr("prec_eca", SPR_ECA, 32'h2);
    rfe = 1'b1;
    spr_sel = SPR_SR; spr_wdata = 32'h11; spr_we = 1'b1;
    tick();
    clear_inputs();
    chk_spr("prec_rfe_sr", SPR_SR, 32'hFF);

    // PEND is read-only.
    spr_write(SPR_PEND, 32'hFFFF_FFFF);
    chk_spr("pend_ro", SPR_PEND, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/exception_unit.md
EXCEPTION_UNIT -- requirements
Module: exception_unit

Interface
REQ-001 Parameters, one per line:
- NCAUSE, default 32, total cause lines.
- NINT, default 8, internal causes at indices 0..NINT-1; external lines occupy NINT..NCAUSE-1.
- NNMI, default 1, causes 0..NNMI-1 non-maskable.
- REPEAT_MASK, default 32'h0000_0018, bit i=1 means cause i is repeat-type, else continue-type.
- DW, default 32, datapath/SPR width.
REQ-002 Ports, one per line (name direction width meaning):
- clk input 1 clock; all state changes on rising edge.
- rst input 1 reset, synchronous, active-high.
- ca_int input NINT internal cause levels from the executing instruction.
- stage_valid input 1 qualifies ca_int.
- ext_irq input NCAUSE-NINT asynchronous external request lines.
- pc input DW address of the faulting instruction.
- next_pc input DW address of the following instruction.
- ea input DW effective address of the instruction.
- rfe input 1 return-from-exception committed this cycle.
- spr_sel input 3 SPR index.
- spr_we input 1 SPR write strobe.
- spr_wdata input DW SPR write data.
- spr_rdata output DW SPR read data.
- mca output NCAUSE masked cause vector.
- il output $clog2(NCAUSE) highest-priority active cause.
- jisr output 1 jump to interrupt service routine.
- mode output 1 current mode, 1=user, 0=system.
- abort output 1 double fault; core halted.

Function
REQ-003 Cause assembly: ca_eff = {pending, ca_int & {NINT{stage_valid}}}.
REQ-004 Masking: mca[i] = ca_eff[i] & (i<NNMI | SR[i]); combinational.
REQ-005 Priority:
- il = lowest set index of mca.
- il = 0 when mca = 0.
REQ-006 jisr = |mca & state==RUN; combinational, same cycle as the cause.
REQ-007 External synchronisation, per line:
- 2-flop synchroniser, then rising-edge detect.
- Line sampled high at edge k sets pending[i] at edge k+2.
REQ-008 Pending clear: pending[i] clears on the edge where jisr=1 and il=NINT+i. A simultaneous new rising edge on the same line wins (stays set).
REQ-009 SPR map, read combinationally via spr_sel:
- 0 SR, 1 ESR, 2 ECA, 3 EPC, 4 EDATA, 5 MODE, 6 EMODE, 7 PEND (read-only).
REQ-010 On the edge with jisr=1:
- ESR<=SR, SR<=0, ECA<=mca.
- EPC<=REPEAT_MASK[il] ? pc : next_pc.
- EDATA<=ea, EMODE<=MODE, MODE<=0, in_isr<=1.
REQ-011 rfe (no jisr): SR<=ESR, MODE<=EMODE, in_isr<=0.
REQ-012 SPR writes:
- spr_we writes the selected SPR on the edge; width DW, upper bits zero-extended for MODE/EMODE.
- Writes to index 7 are ignored.
REQ-013 Same-edge precedence: jisr > rfe > spr_we. Lower-priority updates to the same SPR are discarded.
REQ-014 State machine:
- States RUN and HALT.
- RUN->HALT when jisr conditions hold and in_isr=1 and SR=0 (double fault).
- In that cycle jisr is forced to 0 and no SPR is updated.
- HALT is left only by rst.
REQ-015 abort=1 exactly while state==HALT. In HALT, pending keeps accumulating and SPR writes are ignored.
REQ-016 Nesting is permitted when software sets SR!=0 inside a handler; in_isr remains 1.

Reset
REQ-017 On rst, at the next edge:
- SR, ESR, ECA, EPC, EDATA, EMODE = 0; MODE=0.
- pending=0, synchronisers=0, in_isr=0, state=RUN.
- Outputs: jisr=0, abort=0, mca=0, il=0.
REQ-018 rst overrides every simultaneous event, including an in-progress jisr or a HALT state.

Structure
REQ-019 Package exc_pkg holds:
- SPR index constants.
- State enum {RUN, HALT}.
- Default parameter values.
- Cause index constants: 0 reset, 1 ill, 2 mal, 3 pff, 4 pfls, 5 sysc, 6 ovf.
REQ-020 A single sub-module exc_prio_enc implements the parametrised lowest-index priority encoder (inputs: vector; outputs: index, any).

Verification
REQ-021 Write SR=0xFFFF_FFFF, pulse ext_irq[0] high one cycle at edge k -> PEND[8]=1 after edge k+2, jisr=1 and il=8 in the following cycle, then ECA=0x100 and PEND=0.
REQ-022 stage_valid=1, ca_int=0x42, pc=0x100, next_pc=0x104 -> il=1, ECA=0x42, EPC=0x104, MODE=0, SR=0.
REQ-023 ca_int=0x08 (pff), pc=0x200 -> EPC=0x200 (repeat); then rfe -> SR and MODE restored to pre-entry values.
REQ-024 SR=0, external line 3 raised -> no jisr, PEND[11]=1; write SR=0x800 -> jisr next cycle with il=11.
REQ-025 Inside handler (in_isr=1, SR=0), raise ca_int[0] -> jisr=0, abort=1, state HALT persists 10 cycles; rst -> abort=0, all SPRs 0.
REQ-026 Same edge jisr, rfe and spr_we to SR -> SR=0, ESR=old SR; the rfe and write are discarded.
